reorder_fifo: RTL and testbench

- Parametrised successor to the team's in-order FIFO. Entries are allocated in order and tagged with an ID. Data is written back out of order by ID. Entries retire strictly in allocation order.
- Sits between the request issue path and the response path of the reorder buffer. Responses from multiple back-ends are restored to issue order.
- Full and empty semantics match the plain FIFO, extended with per-slot completion state.

---
 rtl/reorder_fifo_pkg.sv | 21 ++
 rtl/reorder_fifo_slot.sv | 50 +++++
 rtl/reorder_fifo.sv | 126 ++++++++++++
 tb/tb_reorder_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_fifo_pkg.sv
// Shared types and helpers for the reorder FIFO.
// Optional feature macro used by the top: REORDER_FIFO_ERR_EN.
package reorder_fifo_pkg;

  // Lifecycle of one slot: allocated in order, completed out of order, retired in order.
  typedef enum logic [1:0] {
    FREE    = 2'b00,
    PENDING = 2'b01,
    DONE    = 2'b10
  } slot_state_e;

  // Occupancy from two wrap-bit pointers, modulo 2^ptr_w.
  function automatic logic [31:0] ptr_count(input logic [31:0] tail,
                                            input logic [31:0] head,
                                            input int          ptr_w);
    logic [31:0] mask;
    mask = (32'd1 << ptr_w) - 32'd1;
    return (tail - head) & mask;
  endfunction

endpackage

// File: rtl/reorder_fifo_slot.sv
// One reorder FIFO slot: completion state plus payload register.
// A write only lands while the slot is PENDING; otherwise it is ignored.
module reorder_fifo_slot
  import reorder_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_i,
  input  logic                  wr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  retire_i,
  output slot_state_e           state_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  slot_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  // Next-state and payload capture for the slot lifecycle.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    case (state_q)
      FREE:    if (alloc_i) state_d = PENDING;
      PENDING: if (wr_i) begin
        state_d = DONE;
        data_d  = wr_data_i;
      end
      DONE:    if (retire_i) state_d = FREE;
      default: state_d = FREE;
    endcase
  end

  // State and payload registers; reset clears both.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= FREE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign state_o = state_q;
  assign data_o  = data_q;

endmodule

// File: rtl/reorder_fifo.sv
// Reorder FIFO: in-order allocation, out-of-order completion by ID,
// in-order retirement. Optional macro REORDER_FIFO_ERR_EN adds err_o/err_id_o,
// a registered one-cycle pulse reporting a dropped completion write.
module reorder_fifo
  import reorder_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int ID_WIDTH   = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  alloc_valid_i,
  output logic                  alloc_ready_o,
  output logic [ID_WIDTH-1:0]   alloc_id_o,
  input  logic                  wr_valid_i,
  input  logic [ID_WIDTH-1:0]   wr_id_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  ret_valid_o,
  input  logic                  ret_ready_i,
  output logic [ID_WIDTH-1:0]   ret_id_o,
  output logic [DATA_WIDTH-1:0] ret_data_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ID_WIDTH:0]     count_o
`ifdef REORDER_FIFO_ERR_EN
  ,
  output logic                  err_o,
  output logic [ID_WIDTH-1:0]   err_id_o
`endif
);

  localparam int PTR_W = ID_WIDTH + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("reorder_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [ID_WIDTH-1:0]   head_idx, tail_idx;
  logic                  alloc_fire, ret_fire;
  logic [DEPTH-1:0]      slot_alloc, slot_wr, slot_ret;
  slot_state_e           slot_st   [DEPTH];
  logic [DATA_WIDTH-1:0] slot_data [DEPTH];

  assign head_idx = head_q[ID_WIDTH-1:0];
  assign tail_idx = tail_q[ID_WIDTH-1:0];

  assign empty_o       = (head_q == tail_q);
  assign full_o        = (head_q[ID_WIDTH] != tail_q[ID_WIDTH]) && (head_idx == tail_idx);
  assign count_o       = PTR_W'(ptr_count(32'(tail_q), 32'(head_q), PTR_W));
  assign alloc_ready_o = !full_o;
  assign alloc_id_o    = tail_idx;

  // Retire looks only at registered slot state, so a same-cycle write never retires.
  assign ret_valid_o = !empty_o && (slot_st[head_idx] == DONE);
  assign ret_id_o    = head_idx;
  assign ret_data_o  = slot_data[head_idx];

  assign alloc_fire = alloc_valid_i && alloc_ready_o;
  assign ret_fire   = ret_valid_o && ret_ready_i;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    assign slot_alloc[i] = alloc_fire && (tail_idx == ID_WIDTH'(i));
    assign slot_wr[i]    = wr_valid_i && (wr_id_i == ID_WIDTH'(i));
    assign slot_ret[i]   = ret_fire && (head_idx == ID_WIDTH'(i));

    reorder_fifo_slot #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_slot (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .alloc_i   (slot_alloc[i]),
      .wr_i      (slot_wr[i]),
      .wr_data_i (wr_data_i),
      .retire_i  (slot_ret[i]),
      .state_o   (slot_st[i]),
      .data_o    (slot_data[i])
    );
  end

  // Pointer advance on alloc and retire handshakes.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (alloc_fire) tail_d = tail_q + PTR_W'(1);
    if (ret_fire)   head_d = head_q + PTR_W'(1);
  end

  // Head/tail pointer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

`ifdef REORDER_FIFO_ERR_EN
  logic                err_q, err_d;
  logic [ID_WIDTH-1:0] err_id_q, err_id_d;

  // Flag any write that hits a slot not waiting for completion.
  always_comb begin
    err_d    = wr_valid_i && (slot_st[wr_id_i] != PENDING);
    err_id_d = err_d ? wr_id_i : err_id_q;
  end

  // Registered error pulse and offending ID.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign err_o    = err_q;
  assign err_id_o = err_id_q;
`endif

endmodule

// File: tb/tb_reorder_fifo.sv
// Self-checking bench for reorder_fifo (DEPTH=4, DATA_WIDTH=8): directed
// scenarios followed by random traffic against a queue-based reference model.
module tb_reorder_fifo;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       alloc_valid_i;
  logic       alloc_ready_o;
  logic [1:0] alloc_id_o;
  logic       wr_valid_i;
  logic [1:0] wr_id_i;
  logic [7:0] wr_data_i;
  logic       ret_valid_o;
  logic       ret_ready_i;
  logic [1:0] ret_id_o;
  logic [7:0] ret_data_o;
  logic       full_o;
  logic       empty_o;
  logic [2:0] count_o;
`ifdef REORDER_FIFO_ERR_EN
  logic       err_o;
  logic [1:0] err_id_o;
`endif

  always #5 clk_i = ~clk_i;

  reorder_fifo #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .alloc_valid_i (alloc_valid_i),
    .alloc_ready_o (alloc_ready_o),
    .alloc_id_o    (alloc_id_o),
    .wr_valid_i    (wr_valid_i),
    .wr_id_i       (wr_id_i),
    .wr_data_i     (wr_data_i),
    .ret_valid_o   (ret_valid_o),
    .ret_ready_i   (ret_ready_i),
    .ret_id_o      (ret_id_o),
    .ret_data_o    (ret_data_o),
    .full_o        (full_o),
    .empty_o       (empty_o),
    .count_o       (count_o)
`ifdef REORDER_FIFO_ERR_EN
    ,
    .err_o         (err_o),
    .err_id_o      (err_id_o)
`endif
  );

  // Reference model: the in-flight entries in allocation order.
  typedef struct {
    logic [1:0] id;
    bit         done;
  } ent_t;

  ent_t       q[$];
  logic [7:0] mem [4];
  int         tail_id, head_id;
  bit         exp_err;
  logic [1:0] exp_err_id;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    for (int k = 0; k < 4; k++) mem[k] = 8'h00;
    tail_id    = 0;
    head_id    = 0;
    exp_err    = 1'b0;
    exp_err_id = 2'd0;
  endtask

  task automatic check_model(input string where);
    chk({where, ":alloc_ready"}, alloc_ready_o, q.size() < 4);
    chk({where, ":alloc_id"},    alloc_id_o, tail_id);
    chk({where, ":ret_valid"},   ret_valid_o, (q.size() > 0) && q[0].done);
    chk({where, ":ret_id"},      ret_id_o, head_id);
    chk({where, ":ret_data"},    ret_data_o, mem[head_id]);
    chk({where, ":full"},        full_o, q.size() == 4);
    chk({where, ":empty"},       empty_o, q.size() == 0);
    chk({where, ":count"},       count_o, q.size());
`ifdef REORDER_FIFO_ERR_EN
    chk({where, ":err"},         err_o, exp_err);
    chk({where, ":err_id"},      err_id_o, exp_err_id);
`endif
  endtask

  // Advance the model by one clock edge, all decisions taken on pre-edge state.
  task automatic model_apply(input bit av, input bit wv, input logic [1:0] wid,
                             input logic [7:0] wd, input bit rr);
    bit pre_full;
    bit fire_ret;
    int idx;
    pre_full = (q.size() == 4);
    fire_ret = (q.size() > 0) && q[0].done && rr;
    idx = -1;
    if (wv) begin
      for (int k = 0; k < q.size(); k++)
        if (q[k].id == wid && !q[k].done) idx = k;
    end
    if (idx >= 0) begin
      q[idx].done = 1'b1;
      mem[wid]    = wd;
    end
    exp_err = wv && (idx < 0);
    if (exp_err) exp_err_id = wid;
    if (fire_ret) begin
      void'(q.pop_front());
      head_id = (head_id + 1) % 4;
    end
    if (av && !pre_full) begin
      q.push_back('{id: 2'(tail_id), done: 1'b0});
      tail_id = (tail_id + 1) % 4;
    end
  endtask

  task automatic step(input bit av, input bit wv, input logic [1:0] wid,
                      input logic [7:0] wd, input bit rr);
    alloc_valid_i = av;
    wr_valid_i    = wv;
    wr_id_i       = wid;
    wr_data_i     = wd;
    ret_ready_i   = rr;
    @(negedge clk_i);
    check_model("pre");
    model_apply(av, wv, wid, wd, rr);
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni        = 1'b0;
    alloc_valid_i = 1'($urandom);
    wr_valid_i    = 1'b1;
    wr_id_i       = 2'($urandom);
    wr_data_i     = 8'($urandom);
    ret_ready_i   = 1'b1;
    @(posedge clk_i);
    #1;
    rst_ni        = 1'b1;
    alloc_valid_i = 1'b0;
    wr_valid_i    = 1'b0;
    ret_ready_i   = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [1:0] rid;
    rst_ni        = 1'b0;
    alloc_valid_i = 1'b0;
    wr_valid_i    = 1'b0;
    wr_id_i       = 2'd0;
    wr_data_i     = 8'd0;
    ret_ready_i   = 1'b0;
    model_reset();
    @(posedge clk_i);
    #1;
    do_reset();
    chk("reset_alloc_ready", alloc_ready_o, 1);
    chk("reset_empty", empty_o, 1);
    chk("reset_count", count_o, 0);
    chk("reset_ret_valid", ret_valid_o, 0);

    // In-order fill and drain.
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    chk("fill_full", full_o, 1);
    chk("fill_alloc_ready", alloc_ready_o, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 2'(i), 8'(8'hA0 + i), 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", ret_data_o, 8'hA0 + i);
      step(0, 0, 0, 0, 1);
    end
    chk("drain_empty", empty_o, 1);

    // Out-of-order completion (from a fresh reset so IDs start at 0).
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 1, 2, 8'h22, 1);
    chk("ooo_wait_head", ret_valid_o, 0);
    step(0, 1, 0, 8'h00, 1);
    chk("ooo_head_ready", ret_valid_o, 1);
    chk("ooo_head_data", ret_data_o, 8'h00);
    step(0, 0, 0, 0, 1);
    chk("ooo_wait_id1", ret_valid_o, 0);
    step(0, 1, 1, 8'h11, 1);
    chk("ooo_id1_data", ret_data_o, 8'h11);
    step(0, 0, 0, 0, 1);
    chk("ooo_id2_data", ret_data_o, 8'h22);
    step(0, 0, 0, 0, 1);
    chk("ooo_empty", empty_o, 1);

    // Full plus retire in the same cycle: alloc refused, then ID0 next cycle.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
    step(0, 1, 0, 8'h5A, 0);
    step(1, 0, 0, 0, 1);
    chk("fullret_count", count_o, 3);
    chk("fullret_ready", alloc_ready_o, 1);
    chk("fullret_id", alloc_id_o, 0);
    step(1, 0, 0, 0, 0);
    chk("fullret_refill", full_o, 1);

    // Illegal writes: to a FREE slot and a second write to a DONE slot.
    do_reset();
    step(1, 0, 0, 0, 0);
    step(0, 1, 3, 8'h33, 0);
`ifdef REORDER_FIFO_ERR_EN
    chk("illegal_err_free", err_o, 1);
    chk("illegal_err_id3", err_id_o, 3);
`endif
    step(0, 1, 0, 8'h10, 0);
    step(0, 1, 0, 8'h99, 0);
`ifdef REORDER_FIFO_ERR_EN
    chk("illegal_err_done", err_o, 1);
    chk("illegal_err_id0", err_id_o, 0);
`endif
    chk("illegal_keep_data", ret_data_o, 8'h10);
    step(0, 0, 0, 0, 1);
    chk("illegal_no_second", ret_valid_o, 0);
    step(1, 1, 1, 8'h44, 0);
    chk("same_cycle_alloc_write", ret_valid_o, 0);
    step(0, 0, 0, 0, 1);

    // Wrap-around: alloc/write/retire rounds.
    do_reset();
    for (int r = 0; r < 10; r++) begin
      chk("wrap_id", alloc_id_o, r % 4);
      step(1, 0, 0, 0, 0);
      step(0, 1, 2'(r % 4), 8'(8'hC0 + r), 0);
      chk("wrap_data", ret_data_o, 8'hC0 + r);
      step(0, 0, 0, 0, 1);
    end

    // Reset mid-operation.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    step(0, 1, 1, 8'h77, 0);
    do_reset();
    check_model("midreset");
    chk("midreset_id", alloc_id_o, 0);
    chk("midreset_data", ret_data_o, 0);
    step(1, 0, 0, 0, 0);
    chk("midreset_count", count_o, 1);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
      end else begin
        if (q.size() > 0 && $urandom_range(0, 3) != 0)
          rid = q[$urandom_range(0, q.size() - 1)].id;
        else
          rid = 2'($urandom);
        step(1'($urandom), $urandom_range(0, 2) != 0, rid, 8'($urandom), 1'($urandom));
      end
    end
    @(negedge clk_i);
    check_model("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
